// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//   Read-side drain engine for the synchronous FIFO. It issues read enables and
//   turns the FIFO empty/rd_en/rdata interface into a valid/ready stream. The
//   FIFO's 1-cycle read latency is absorbed by a 2-entry output buffer, so
//   downstream backpressure never drops a word. The FIFO is never read while
//   empty.
//
// Parameters
//   WIDTH      data width (must match the FIFO data width)
//   CNT_WIDTH  transfer counter width (only with FIFO_READER_CNT_EN)
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-low reset
//   en_i          1 = allow new FIFO reads
//   fifo_empty_i  FIFO empty flag
//   fifo_rdata_i  FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_rd_en_o  FIFO read enable
//   m_valid_o     output word valid
//   m_data_o      output word (0 while the buffer is empty)
//   m_ready_i     consumer ready
//   idle_o        buffer empty and no read in flight
//   xfer_cnt_o    words delivered, wrapping (only with FIFO_READER_CNT_EN)
//
// Optional feature: define FIFO_READER_CNT_EN to add the xfer_cnt_o counter.
// -----------------------------------------------------------------------------
module fifo_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 fifo_empty_i,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    output logic                 fifo_rd_en_o,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    input  logic                 m_ready_i,
    output logic                 idle_o
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] xfer_cnt_o
`endif
);

    logic [WIDTH-1:0] r_buf [2];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_cnt;
    logic             r_inflight;

    logic             w_pop;
    logic             w_rd_en;
    logic [2:0]       w_occ;

    assign m_valid_o = (r_cnt != 2'd0);
    assign m_data_o  = m_valid_o ? r_buf[r_head] : '0;
    assign w_pop     = m_valid_o & m_ready_i;

    // Occupancy after this cycle's pop, counting the word still in flight.
    // Keeping it below 2 guarantees the captured word always has a free slot.
    assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    // rst_i gates the enable so no read is issued while reset is held.
    assign w_rd_en = rst_i & en_i & ~fifo_empty_i & (w_occ < 3'd2);

    assign fifo_rd_en_o = w_rd_en;
    assign idle_o       = (r_cnt == 2'd0) & ~r_inflight;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_cnt      <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (r_inflight) begin
                r_buf[r_tail] <= fifo_rdata_i;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            // Simultaneous capture and pop leaves the count unchanged.
            case ({r_inflight, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef FIFO_READER_CNT_EN
    logic [CNT_WIDTH-1:0] r_xfer_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_xfer_cnt <= '0;
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + 1'b1;
        end
    end

    assign xfer_cnt_o = r_xfer_cnt;
`endif

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Read-side drain engine for the team's synchronous FIFO: it issues FIFO read enables and converts the FIFO's empty/rd_en/rdata interface into a valid/ready output stream.
- It never reads an empty FIFO, so the FIFO's read-error output stays low.
- It absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer, so downstream backpressure never loses data.
- It sits between the FIFO read port and any streaming consumer.

Parameters:
WIDTH, 8, data width; must equal the FIFO data width.
CNT_WIDTH, 16, width of the transfer counter (used only with the optional feature).

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  reset, asynchronous, active-low (0 = reset).
en_i  input  1  1 = allow new FIFO reads; 0 = stop issuing reads.
fifo_empty_i  input  1  FIFO empty flag.
fifo_rdata_i  input  WIDTH  FIFO read data; valid the cycle after fifo_rd_en_o was high.
fifo_rd_en_o  output  1  FIFO read enable.
m_valid_o  output  1  output word valid.
m_data_o  output  WIDTH  output word.
m_ready_i  input  1  consumer accepts m_data_o when m_valid_o=1.
idle_o  output  1  1 = buffer empty and no read in flight.

Behaviour:
- Reset (rst_i=0, asynchronous): buffer count=0, in-flight flag=0, both buffer entries=0. Outputs: m_valid_o=0, m_data_o=0, idle_o=1. fifo_rd_en_o=0 while rst_i=0.
- Reset mid-operation discards buffered words and any in-flight read; that word is lost and the bench must not expect it.
- State: buf_cnt (0..2), inflight (1 bit; set in the cycle after fifo_rd_en_o=1), 2-entry circular buffer with 1-bit head/tail pointers that wrap 1->0.
- pop = m_valid_o & m_ready_i.
- fifo_rd_en_o (combinational) = en_i & ~fifo_empty_i & ((buf_cnt + inflight - pop) < 2). Sum width is 3 bits, so no underflow.
- Capture: on the edge ending a cycle with inflight=1, fifo_rdata_i is written at tail, tail advances, buf_cnt increments.
- Output: m_valid_o = (buf_cnt != 0). m_data_o = entry at head; it is 0 when the buffer is empty.
- On pop, head advances and buf_cnt decrements.
- Simultaneous capture and pop: buf_cnt unchanged, both pointers advance.
- Latency: rd_en in cycle n -> FIFO data in cycle n+1 -> m_valid_o=1 in cycle n+2.
- Throughput: 1 word/cycle sustained while the FIFO is non-empty and m_ready_i=1.
- Backpressure: with m_ready_i=0, at most 2 words are held (buffered + in flight). fifo_rd_en_o stays 0 until a pop frees space.
- m_valid_o/m_data_o remain stable while m_valid_o=1 and m_ready_i=0.
- en_i 1->0: no new reads; the in-flight word and buffered words are still delivered.
- fifo_empty_i=1: fifo_rd_en_o=0 regardless of other inputs.
- idle_o = (buf_cnt==0) & ~inflight.
- Order preserved: output order equals FIFO read order.

Optional Feature:
- Macro: FIFO_READER_CNT_EN.
- Defined: adds output xfer_cnt_o [CNT_WIDTH-1:0]. Reset value 0; increments by 1 on every pop; wraps from 2^CNT_WIDTH-1 to 0.
- Not defined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Basic drain: FIFO preloaded with 16 words 0x00..0x0F, en_i=1, m_ready_i=1 -> 16 outputs 0x00..0x0F in order, one per cycle. First m_valid_o 2 cycles after the first fifo_rd_en_o. idle_o=1 afterwards. The FIFO's rd_error_o is never 1.
- Backpressure: 4 words 0xA0..0xA3 preloaded, m_ready_i=0 for 10 cycles -> exactly 2 reads issued; m_data_o holds 0xA0 stable. After m_ready_i=1: 0xA0..0xA3 in order, nothing lost or duplicated.
- Empty guard: FIFO empty, en_i=1 for 20 cycles -> fifo_rd_en_o=0 and m_valid_o=0 throughout. Write one word 0x5A -> it is output once.
- Enable stop: 8 words preloaded, en_i dropped after the 3rd fifo_rd_en_o -> exactly 3 words output, 5 remain in the FIFO.
- Async reset mid-stream: rst_i=0 pulsed between clock edges while 2 words are buffered -> m_valid_o=0 and idle_o=1 immediately, with no clock edge required. After release, the next FIFO word is output first.
- Counter (FIFO_READER_CNT_EN, CNT_WIDTH=4): 17 pops -> xfer_cnt_o reads 0x1 after wrap.
